// File: rtl/dmem_lsu_ctrl.sv
// dmem_lsu_ctrl: byte/half/word load-store controller driving a single-port active-low data SRAM
module dmem_lsu_ctrl #(
  parameter int unsigned ADDR_WIDTH = 13,
  parameter logic [31:0] BASE_ADDR  = 32'h0000_0000
) (
  input  logic                  clk_i,
  input  logic                  rst_i,
  input  logic                  req_valid_i,
  output logic                  req_ready_o,
  input  logic [31:0]           req_addr_i,
  input  logic                  req_we_i,
  input  logic [1:0]            req_size_i,
  input  logic                  req_unsigned_i,
  input  logic [31:0]           req_wdata_i,
  output logic                  resp_valid_o,
  output logic [31:0]           resp_rdata_o,
  output logic                  resp_err_o,
  output logic                  sram_csb_o,
  output logic                  sram_we_o,
  output logic [ADDR_WIDTH-1:0] sram_addr_o,
  output logic [31:0]           sram_wdata_o,
  output logic [3:0]            sram_wmask_o,
  input  logic [31:0]           sram_rdata_i
);
  typedef enum logic [1:0] {IDLE, ACCESS, RDWAIT} state_t;
  state_t state, state_nxt;
  logic [31:0] off, wdata_nxt, ext;
  logic [3:0] mask_nxt;
  logic [1:0] lane, sz;
  logic [15:0] half;
  logic [7:0] byt;
  logic uns, is_load, err_pend, accept, bad, go;
  assign req_ready_o = state == IDLE;
  assign accept = req_valid_i && req_ready_o;
  // window test on the rebased offset also rejects addresses below BASE_ADDR via wraparound
  assign off = req_addr_i - BASE_ADDR;
  assign bad = req_size_i == 2'b11 || (req_size_i == 2'b01 && req_addr_i[0]) ||
               (req_size_i == 2'b10 && req_addr_i[1:0] != 2'b00) || (off >> (ADDR_WIDTH + 2)) != 32'd0;
  assign go = accept && !bad;
  assign mask_nxt = req_size_i == 2'b00 ? 4'b0001 << req_addr_i[1:0] :
                    req_size_i == 2'b01 ? 4'b0011 << req_addr_i[1:0] : 4'b1111;
  assign wdata_nxt = req_size_i == 2'b00 ? {4{req_wdata_i[7:0]}} :
                     req_size_i == 2'b01 ? {2{req_wdata_i[15:0]}} : req_wdata_i;
  always_comb begin
    state_nxt = state == IDLE ? (go ? ACCESS : IDLE) : state == ACCESS ? (is_load ? RDWAIT : IDLE) : IDLE;
    byt = sram_rdata_i[{lane, 3'b000} +: 8];
    half = lane[1] ? sram_rdata_i[31:16] : sram_rdata_i[15:0];
    ext = sz == 2'b00 ? {{24{!uns && byt[7]}}, byt} :
          sz == 2'b01 ? {{16{!uns && half[15]}}, half} : sram_rdata_i;
  end
  always_ff @(posedge clk_i or posedge rst_i)
    if (rst_i) begin
      state        <= IDLE;
      err_pend     <= 1'b0;
      sram_csb_o   <= 1'b1;
      sram_we_o    <= 1'b1;
      sram_addr_o  <= '0;
      sram_wdata_o <= '0;
      sram_wmask_o <= '0;
      lane         <= '0;
      sz           <= '0;
      uns          <= 1'b0;
      is_load      <= 1'b0;
      resp_valid_o <= 1'b0;
      resp_err_o   <= 1'b0;
      resp_rdata_o <= '0;
    end else begin
      state        <= state_nxt;
      err_pend     <= accept && bad;
      sram_csb_o   <= !go;
      sram_we_o    <= !(go && req_we_i);
      sram_wmask_o <= go && req_we_i ? mask_nxt : 4'b0000;
      if (go) begin
        sram_addr_o <= off[ADDR_WIDTH+1:2];
        lane        <= req_addr_i[1:0];
        sz          <= req_size_i;
        uns         <= req_unsigned_i;
        is_load     <= !req_we_i;
      end
      if (go && req_we_i) sram_wdata_o <= wdata_nxt;
      resp_valid_o <= err_pend || (state == ACCESS && !is_load) || state == RDWAIT;
      resp_err_o   <= err_pend;
      resp_rdata_o <= state == RDWAIT ? ext : 32'd0;
    end
endmodule

// File: tb/tb_dmem_lsu_ctrl.sv
// tb_dmem_lsu_ctrl: randomized scoreboard bench for dmem_lsu_ctrl against a byte-level memory model
module tb_dmem_lsu_ctrl;
  localparam int AW = 13;
  localparam logic [31:0] BASE = 32'h0;
  localparam logic [31:0] WIN = 32'h8000;
  typedef struct { logic err; logic [31:0] data; int acc; int lat; } exp_t;
  typedef struct { string n; logic [31:0] a; logic [31:0] e; } chk_t;
  logic clk_i = 0, rst_i = 0;
  logic req_valid_i = 0, req_we_i = 0, req_unsigned_i = 0;
  logic [31:0] req_addr_i = 0, req_wdata_i = 0;
  logic [1:0] req_size_i = 0;
  logic req_ready_o, resp_valid_o, resp_err_o, sram_csb_o, sram_we_o;
  logic [31:0] resp_rdata_o, sram_wdata_o;
  logic [31:0] sram_rdata_i = 0;
  logic [AW-1:0] sram_addr_o;
  logic [3:0] sram_wmask_o;
  logic [31:0] mem [0:(1<<AW)-1] = '{default: '0};
  logic [7:0] rm [0:32767] = '{default: '0};
  exp_t q[$];
  chk_t cq[$];
  int total = 0, bad = 0, cyc = 0, acc_cyc = -10;
  logic acc_load = 0;

  dmem_lsu_ctrl #(.ADDR_WIDTH(AW), .BASE_ADDR(BASE)) dut (
    .clk_i(clk_i), .rst_i(rst_i), .req_valid_i(req_valid_i), .req_ready_o(req_ready_o),
    .req_addr_i(req_addr_i), .req_we_i(req_we_i), .req_size_i(req_size_i),
    .req_unsigned_i(req_unsigned_i), .req_wdata_i(req_wdata_i), .resp_valid_o(resp_valid_o),
    .resp_rdata_o(resp_rdata_o), .resp_err_o(resp_err_o), .sram_csb_o(sram_csb_o),
    .sram_we_o(sram_we_o), .sram_addr_o(sram_addr_o), .sram_wdata_o(sram_wdata_o),
    .sram_wmask_o(sram_wmask_o), .sram_rdata_i(sram_rdata_i));

  always #5 clk_i = ~clk_i;
  always @(posedge clk_i) cyc <= cyc + 1;

  always @(posedge clk_i)
    if (!sram_csb_o) begin
      if (!sram_we_o) begin
        for (int i = 0; i < 4; i++) if (sram_wmask_o[i]) mem[sram_addr_o][8*i +: 8] <= sram_wdata_o[8*i +: 8];
      end else sram_rdata_i <= mem[sram_addr_o];
    end

  task automatic chk(input string n, input logic [31:0] a, input logic [31:0] e);
    total++;
    if (a !== e) begin
      bad++;
      $display("FAIL %s: got %h expected %h (cycle %0d)", n, a, e, cyc);
    end
  endtask

  // single checking process: drains driver-side port checks and pops the response scoreboard
  always @(negedge clk_i) begin
    exp_t e;
    chk_t c;
    while (cq.size() > 0) begin
      c = cq.pop_front();
      chk(c.n, c.a, c.e);
    end
    if (!rst_i) begin
      chk("csb", 32'(sram_csb_o), 32'(cyc != acc_cyc));
      chk("ready", 32'(req_ready_o), 32'(!(cyc == acc_cyc || (acc_load && cyc == acc_cyc + 1))));
      if (resp_valid_o) begin
        if (q.size() == 0) chk("spurious_resp", 32'(resp_valid_o), 32'd0);
        else begin
          e = q.pop_front();
          chk("resp_err", 32'(resp_err_o), 32'(e.err));
          chk("resp_rdata", resp_rdata_o, e.data);
          chk("resp_latency", 32'(cyc - e.acc), 32'(e.lat));
        end
      end
    end
  end

  task automatic idle();
    @(negedge clk_i);
    req_valid_i = 0;
  endtask

  task automatic issue(input logic [31:0] a, input logic we, input logic [1:0] sz, input logic u,
                       input logic [31:0] d, output int acc);
    exp_t e;
    int nb, n;
    logic legal;
    logic [31:0] v;
    nb = sz == 2'd0 ? 1 : sz == 2'd1 ? 2 : 4;
    legal = sz != 2'd3 && a % nb == 0 && a - BASE < WIN;
    @(negedge clk_i);
    req_addr_i = a; req_we_i = we; req_size_i = sz; req_unsigned_i = u; req_wdata_i = d; req_valid_i = 1;
    n = 0;
    while (!req_ready_o && n < 20) begin
      @(negedge clk_i);
      n++;
    end
    if (!req_ready_o) begin
      cq.push_back('{"accept_timeout", 32'd0, 32'd1});
      acc = -1;
      return;
    end
    @(posedge clk_i);
    #1;
    acc = cyc;
    v = 0;
    if (!legal) e = '{1'b1, 32'd0, acc, 1};
    else if (we) begin
      for (int i = 0; i < nb; i++) rm[a - BASE + i] = d[8*i +: 8];
      e = '{1'b0, 32'd0, acc, 1};
    end else begin
      for (int i = 0; i < nb; i++) v |= 32'(rm[a - BASE + i]) << (8 * i);
      if (!u && nb < 4 && v[8*nb-1]) v |= 32'hFFFF_FFFF << (8 * nb);
      e = '{1'b0, v, acc, 2};
    end
    q.push_back(e);
    if (legal) begin
      acc_cyc = acc;
      acc_load = !we;
      cq.push_back('{"sram_addr", 32'(sram_addr_o), (a - BASE) >> 2});
      cq.push_back('{"sram_we", 32'(sram_we_o), 32'(!we)});
      cq.push_back('{"sram_wmask", 32'(sram_wmask_o), we ? ((32'd1 << nb) - 32'd1) << (a % 4) : 32'd0});
      if (we) cq.push_back('{"sram_wdata", sram_wdata_o,
                             sz == 2'd0 ? 32'(d[7:0]) * 32'h0101_0101 : sz == 2'd1 ? 32'(d[15:0]) * 32'h0001_0001 : d});
    end
  endtask

  initial begin
    int t0, t1, t2, t3, n;
    logic [31:0] a;
    logic [1:0] sz;
    #1 rst_i = 1;
    #1;
    cq.push_back('{"rst_csb", 32'(sram_csb_o), 32'd1});
    cq.push_back('{"rst_we", 32'(sram_we_o), 32'd1});
    cq.push_back('{"rst_addr", 32'(sram_addr_o), 32'd0});
    cq.push_back('{"rst_wdata", sram_wdata_o, 32'd0});
    cq.push_back('{"rst_wmask", 32'(sram_wmask_o), 32'd0});
    cq.push_back('{"rst_resp_valid", 32'(resp_valid_o), 32'd0});
    cq.push_back('{"rst_resp_rdata", resp_rdata_o, 32'd0});
    cq.push_back('{"rst_resp_err", 32'(resp_err_o), 32'd0});
    cq.push_back('{"rst_ready", 32'(req_ready_o), 32'd1});
    repeat (3) @(negedge clk_i);
    rst_i = 0;
    // word store / load
    issue(32'h10, 1, 2'd2, 0, 32'hDEAD_BEEF, t0);
    issue(32'h10, 0, 2'd2, 0, 32'd0, t0);
    idle();
    // byte and half lanes
    issue(32'h13, 1, 2'd0, 0, 32'h0000_0080, t0);
    issue(32'h13, 0, 2'd0, 0, 32'd0, t0);
    issue(32'h13, 0, 2'd0, 1, 32'd0, t0);
    issue(32'h12, 1, 2'd1, 0, 32'h0000_8001, t0);
    issue(32'h12, 0, 2'd1, 0, 32'd0, t0);
    issue(32'h12, 0, 2'd1, 1, 32'd0, t0);
    idle();
    // error burst, one per cycle
    issue(32'h2, 0, 2'd2, 0, 32'd0, t0);
    issue(32'h5, 1, 2'd1, 0, 32'h1234, t1);
    issue(32'h0, 0, 2'd3, 0, 32'd0, t2);
    issue(32'h8000, 0, 2'd2, 0, 32'd0, t3);
    cq.push_back('{"err_gap", 32'(t3 - t0), 32'd3});
    idle();
    // back-to-back store, store, load with valid held
    issue(32'h40, 1, 2'd2, 0, 32'h0102_0304, t0);
    issue(32'h46, 1, 2'd1, 0, 32'h0000_BEEF, t1);
    issue(32'h40, 0, 2'd2, 0, 32'd0, t2);
    issue(32'h47, 0, 2'd0, 0, 32'd0, t3);
    cq.push_back('{"b2b_gap1", 32'(t1 - t0), 32'd2});
    cq.push_back('{"b2b_gap2", 32'(t2 - t1), 32'd2});
    cq.push_back('{"b2b_gap3", 32'(t3 - t2), 32'd3});
    idle();
    // window edge
    issue(32'h7FFC, 1, 2'd2, 0, 32'hCAFE_F00D, t0);
    issue(32'h7FFC, 0, 2'd2, 0, 32'd0, t0);
    issue(32'h7FFF, 0, 2'd0, 0, 32'd0, t0);
    idle();
    repeat (3) @(negedge clk_i);
    // reset while in RDWAIT drops the pending load response
    issue(32'h10, 0, 2'd2, 0, 32'd0, t0);
    req_valid_i = 0;
    @(posedge clk_i);
    #3 rst_i = 1;
    q.delete();
    acc_cyc = -10;
    #1;
    cq.push_back('{"rst_rdwait_csb", 32'(sram_csb_o), 32'd1});
    cq.push_back('{"rst_rdwait_valid", 32'(resp_valid_o), 32'd0});
    cq.push_back('{"rst_rdwait_ready", 32'(req_ready_o), 32'd1});
    @(negedge clk_i);
    rst_i = 0;
    repeat (5) @(negedge clk_i);
    issue(32'h10, 0, 2'd2, 0, 32'd0, t0);
    idle();
    repeat (3) @(negedge clk_i);
    // reset while in ACCESS drops a store before the SRAM edge
    @(negedge clk_i);
    req_addr_i = 32'h10; req_we_i = 1; req_size_i = 2'd2; req_unsigned_i = 0; req_wdata_i = 32'h1111_1111; req_valid_i = 1;
    @(posedge clk_i);
    #2 rst_i = 1;
    req_valid_i = 0;
    #1;
    cq.push_back('{"rst_access_csb", 32'(sram_csb_o), 32'd1});
    cq.push_back('{"rst_access_valid", 32'(resp_valid_o), 32'd0});
    @(negedge clk_i);
    rst_i = 0;
    repeat (3) @(negedge clk_i);
    issue(32'h10, 0, 2'd2, 0, 32'd0, t0);
    idle();
    // randomized mix
    for (int k = 0; k < 400; k++) begin
      n = $urandom_range(0, 9);
      a = n < 7 ? 32'($urandom_range(0, 127)) : n < 9 ? 32'h7F80 + 32'($urandom_range(0, 127)) : $urandom;
      sz = $urandom_range(0, 9) == 0 ? 2'd3 : 2'($urandom_range(0, 2));
      issue(a, 1'($urandom_range(0, 1)), sz, 1'($urandom_range(0, 1)), $urandom, t0);
      if ($urandom_range(0, 3) == 0) idle();
    end
    idle();
    n = 0;
    while (q.size() > 0 && n < 20) begin
      @(negedge clk_i);
      n++;
    end
    cq.push_back('{"drain", 32'(q.size()), 32'd0});
    @(negedge clk_i);
    @(posedge clk_i);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule

// File: doc/dmem_lsu_ctrl.md
# dmem_lsu_ctrl

Load/store controller that sits directly upstream of the 8K×32 data SRAM wrapper. It accepts single byte/half/word requests from the core's memory stage over a valid/ready handshake. It drives the SRAM's active-low chip-select/write-enable port with word address, replicated write data and byte mask. For loads it extracts, sign- or zero-extends and returns the addressed lane.

## Interface
Parameters:
- ADDR_WIDTH, 13: SRAM word-address width; the SRAM holds 4·2^ADDR_WIDTH bytes.
- BASE_ADDR, 32'h0000_0000: byte base of the SRAM window; must be aligned to 4·2^ADDR_WIDTH.

Ports:
- clk_i  in  1  clock; all state on rising edge.
- rst_i  in  1  reset, asynchronous, active-high.
- req_valid_i  in  1  core request valid.
- req_ready_o  out  1  controller can accept; combinational, high iff state == IDLE.
- req_addr_i  in  32  byte address.
- req_we_i  in  1  1 = store, 0 = load.
- req_size_i  in  2  00 byte, 01 half, 10 word, 11 illegal.
- req_unsigned_i  in  1  load zero-extends when 1, sign-extends when 0.
- req_wdata_i  in  32  store data, right-aligned.
- resp_valid_o  out  1  one-cycle response pulse; the core always accepts it.
- resp_rdata_o  out  32  load result; 0 for stores and errors.
- resp_err_o  out  1  misaligned, out-of-window or illegal size.
- sram_csb_o  out  1  SRAM chip select, active-low.
- sram_we_o  out  1  SRAM write enable, active-low (0 = write).
- sram_addr_o  out  ADDR_WIDTH  SRAM word address.
- sram_wdata_o  out  32  SRAM write data.
- sram_wmask_o  out  4  SRAM byte mask, bit i enables byte i.
- sram_rdata_i  in  32  SRAM read data, valid the cycle after the SRAM samples a read.

## Operation
- FSM states: IDLE, ACCESS, RDWAIT.
- Request handshake:
  - A request is accepted on a rising edge with req_valid_i && req_ready_o.
  - All request fields are captured at acceptance.
- Error check at acceptance. The request is an error if any of:
  - req_size_i == 11;
  - half with addr[0] set;
  - word with addr[1:0] != 0;
  - addr outside [BASE_ADDR, BASE_ADDR + 4·2^ADDR_WIDTH).
- Error path:
  - The SRAM is not touched and the state stays IDLE.
  - Next cycle: resp_valid_o = 1, resp_err_o = 1, resp_rdata_o = 0.
- Legal access:
  - IDLE → ACCESS.
  - Registered SRAM outputs are driven for exactly that one cycle: csb = 0, addr = (req_addr − BASE_ADDR)[ADDR_WIDTH+1:2].
- Store:
  - we = 0.
  - wdata: byte → {4{wdata[7:0]}}, half → {2{wdata[15:0]}}, word → wdata.
  - wmask: byte → 4'b0001 << addr[1:0], half → 4'b0011 << addr[1:0], word → 4'b1111.
  - ACCESS → IDLE; resp_valid_o = 1, resp_err_o = 0 in the following cycle.
- Load:
  - we = 1, wmask = 0.
  - ACCESS → RDWAIT.
  - At the end of RDWAIT: select lane addr[1:0] (byte) or addr[1] (half) of sram_rdata_i, extend per req_unsigned_i, register into resp_rdata_o with resp_valid_o = 1; RDWAIT → IDLE.
- Outside ACCESS:
  - sram_csb_o = 1, sram_we_o = 1, sram_wmask_o = 0.
  - sram_addr_o and sram_wdata_o hold their last values.

## Timing
- Reset values (asynchronous): state IDLE, sram_csb_o = 1, sram_we_o = 1, sram_addr_o = 0, sram_wdata_o = 0, sram_wmask_o = 0, resp_valid_o = 0, resp_rdata_o = 0, resp_err_o = 0.
- req_ready_o is 1 during and after reset.
- For a request accepted at edge T:
  - SRAM samples at edge T+1.
  - Store/error response is valid in cycle T+1..T+2.
  - Load response is valid in cycle T+2..T+3.
- resp_valid_o is high for exactly one cycle per accepted request. Responses return in request order.
- req_ready_o is high in the response cycle of a store or error, so a new request may be accepted there.
- Peak throughput: one store per 2 cycles, one load per 3 cycles, one error per cycle.
- req_valid_i while not ready: fields are ignored. The core must hold them.
- Reset mid-operation (ACCESS or RDWAIT):
  - sram_csb_o goes high immediately and no response is emitted.
  - A store whose SRAM edge has not occurred is dropped.

## Test plan
- Word store then load: store 32'hDEADBEEF at 0x0000_0010 → csb = 0, we = 0, addr = 4, wmask = 1111 for one cycle; resp at T+1. Load same address → resp_rdata_o = 32'hDEADBEEF at T+2, err = 0.
- Byte/half lanes:
  - Store byte 8'h80 at 0x13 → wdata = 32'h80808080, wmask = 1000.
  - Signed byte load of 0x13 → 32'hFFFF_FF80; unsigned → 32'h0000_0080.
  - Half load of 0x12 with memory 32'h8001_xxxx → signed 32'hFFFF_8001.
- Errors:
  - Word at 0x2, half at 0x5, size 11, address 0x0000_8000 → each gives resp_err_o = 1, rdata 0 at T+1, with csb never low.
- Back-to-back: hold req_valid_i with store, store, load → accepted at T, T+2, T+4; load data at T+6; ready never high in ACCESS/RDWAIT.
- Reset in RDWAIT: assert rst_i asynchronously mid-cycle → csb = 1, resp_valid_o = 0 immediately; no later response; next request is served normally.
- Window edge: last word 0x7FFC loads correctly (addr = 13'h1FFF); 0x8000 errors.
